// File: rtl/cpu_pipe_pkg.sv
// Shared defaults for the pipeline register chain and the helper that sizes occupancy counters.
package cpu_pipe_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefDepth = 4;
    localparam int unsigned DefCntW  = 16;
    localparam logic [DefWidth-1:0] DefBubble = '0;

    // Bits needed to hold any value in 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: valid bit plus payload with flush > stall > load > advance priority.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH  = DefWidth,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(DefBubble)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            data_d  = BUBBLE;
        end else if (stall_i) begin
            valid_d = valid_q;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (adv_i) begin
            valid_d = 1'b0;
            data_d  = BUBBLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            data_q  <= BUBBLE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH back-to-back valid/payload registers with per-stage stall/flush, end-to-end flow control,
// occupancy and a saturating count of entries dropped by flush.
module pipe_stage_chain
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH  = DefWidth,
    parameter int unsigned      DEPTH  = DefDepth,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(DefBubble),
    parameter int unsigned      CNT_W  = DefCntW
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    input  logic [WIDTH-1:0]             in_data_i,
    output logic                         in_ready_o,
    output logic                         out_valid_o,
    output logic [WIDTH-1:0]             out_data_o,
    input  logic                         out_ready_i,
    input  logic [DEPTH-1:0]             stall_i,
    input  logic [DEPTH-1:0]             flush_i,
    output logic [DEPTH-1:0]             stage_valid_o,
    output logic [DEPTH*WIDTH-1:0]       stage_data_o,
    output logic [cnt_width(DEPTH)-1:0]  count_o,
    output logic [CNT_W-1:0]             squash_cnt_o
);

    localparam int unsigned CountW = cnt_width(DEPTH);
    localparam int unsigned AddW   = cnt_width(2 * DEPTH);
    localparam int unsigned SumW   = ((CNT_W > AddW) ? CNT_W : AddW) + 1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [DEPTH-1:0] accept, adv, load;
    logic             down;

    // Accept ripples combinationally from the output port back to stage 0.
    always_comb begin
        accept = '0;
        adv    = '0;
        load   = '0;
        down   = out_ready_i;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            adv[k]    = stage_valid_o[k] & ~flush_i[k] & ~stall_i[k] & down;
            accept[k] = flush_i[k] | (~stall_i[k] & (~stage_valid_o[k] | adv[k]));
            down      = accept[k];
        end
        load[0] = in_valid_i & accept[0];
        for (int k = 1; k < int'(DEPTH); k++) begin
            load[k] = adv[k-1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        if (k == 0) begin : g_head
            assign d_in = in_data_i;
        end else begin : g_body
            assign d_in = stage_data_o[(k-1)*WIDTH +: WIDTH];
        end

        pipe_stage_reg #(
            .WIDTH  (WIDTH),
            .BUBBLE (BUBBLE)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i[k]),
            .stall_i (stall_i[k]),
            .load_i  (load[k]),
            .adv_i   (adv[k]),
            .data_i  (d_in),
            .valid_o (stage_valid_o[k]),
            .data_o  (stage_data_o[k*WIDTH +: WIDTH])
        );
    end

    assign in_ready_o  = accept[0];
    assign out_valid_o = stage_valid_o[DEPTH-1];
    assign out_data_o  = stage_data_o[(DEPTH-1)*WIDTH +: WIDTH];

    always_comb begin
        count_o = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            count_o = count_o + CountW'(stage_valid_o[k]);
        end
    end

    // Drops: entries held in a flushed stage plus entries moving into a flushed stage.
    logic [AddW-1:0]  squash_add;
    logic [SumW-1:0]  squash_sum;
    logic [CNT_W-1:0] squash_q, squash_d;

    always_comb begin
        squash_add = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            squash_add = squash_add + AddW'(stage_valid_o[k] & flush_i[k])
                                    + AddW'(load[k] & flush_i[k]);
        end
        squash_sum = SumW'(squash_q) + SumW'(squash_add);
        squash_d   = (squash_sum > SumW'(CntMax)) ? CntMax : squash_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            squash_q <= '0;
        end else begin
            squash_q <= squash_d;
        end
    end

    assign squash_cnt_o = squash_q;

endmodule
